// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

  localparam int                    DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

  // True when a select value addresses an existing output channel.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// The slot drives its idle value whenever it is empty.
module demux_slot #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] IDLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data
);

  // A load wins over a drain, so a beat can be replaced in the cycle it leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= IDLE_VAL;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
      data  <= IDLE_VAL;
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer.
// Handshake: a beat moves on any port in a cycle where valid and ready are both
// high; valid never waits for ready, and ready never looks at valid on the same port.
// Beats whose select addresses no channel are accepted, dropped and counted.
module stream_demux_1xn
  import demux_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                N_OUT    = 4,
  parameter logic [DATA_W-1:0] IDLE_VAL = '0,
  // Derived from N_OUT; leave at its default.
  parameter int                SEL_W    = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  logic             sel_ok;
  logic             slot_free;
  logic             accept;
  logic             bad_beat;
  logic [N_OUT-1:0] load;

  assign sel_ok = sel_in_range(32'(in_sel), N_OUT);

  // Selected slot can take a beat when it is empty or draining this cycle.
  always_comb begin
    slot_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (in_sel == SEL_W'(k)) slot_free = ~out_valid[k] | out_ready[k];
    end
  end

  // Out-of-range beats are always taken so a bad select can never stall the producer.
  assign in_ready = rst_n & (sel_ok ? slot_free : 1'b1);
  assign accept   = in_valid & in_ready;
  assign bad_beat = accept & ~sel_ok;

  // One-hot load strobe for the addressed slot.
  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = accept & sel_ok & (in_sel == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_slot #(
      .DATA_W   (DATA_W),
      .IDLE_VAL (IDLE_VAL)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (in_data),
      .valid     (out_valid[g]),
      .ready     (out_ready[g]),
      .data      (out_data[g*DATA_W +: DATA_W])
    );
  end

  // Drop reporting: one-cycle error pulse per dropped beat and a saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= bad_beat;
      if (bad_beat && drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: a 4-channel instance for steering, back-pressure,
// reset and random traffic, and a 5-channel instance for out-of-range selects.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst_n_4;
  logic        in_valid_4;
  logic        in_ready_4;
  logic [7:0]  in_data_4;
  logic [1:0]  in_sel_4;
  logic [3:0]  out_valid_4;
  logic [3:0]  out_ready_4;
  logic [31:0] out_data_4;
  logic        sel_err_4;
  logic [7:0]  drop_cnt_4;

  // 5-channel instance
  logic        rst_n_5;
  logic        in_valid_5;
  logic        in_ready_5;
  logic [7:0]  in_data_5;
  logic [2:0]  in_sel_5;
  logic [4:0]  out_valid_5;
  logic [4:0]  out_ready_5;
  logic [39:0] out_data_5;
  logic        sel_err_5;
  logic [7:0]  drop_cnt_5;

  stream_demux_1xn #(.DATA_W(8), .N_OUT(4)) dut_4 (
    .clk(clk), .rst_n(rst_n_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .in_data(in_data_4), .in_sel(in_sel_4), .out_valid(out_valid_4),
    .out_ready(out_ready_4), .out_data(out_data_4), .sel_err(sel_err_4),
    .drop_cnt(drop_cnt_4)
  );

  stream_demux_1xn #(.DATA_W(8), .N_OUT(5)) dut_5 (
    .clk(clk), .rst_n(rst_n_5), .in_valid(in_valid_5), .in_ready(in_ready_5),
    .in_data(in_data_5), .in_sel(in_sel_5), .out_valid(out_valid_5),
    .out_ready(out_ready_5), .out_data(out_data_5), .sel_err(sel_err_5),
    .drop_cnt(drop_cnt_5)
  );

  int checks = 0;
  int errors = 0;

  // Per-channel expected beats for the random phase.
  logic [7:0] exp_q [4][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat on the 4-channel instance and let combinational paths settle.
  task automatic drive_4(input logic v, input logic [1:0] sel, input logic [7:0] d);
    in_valid_4 = v;
    in_sel_4   = sel;
    in_data_4  = d;
    #1;
  endtask

  task automatic expect_out_4(input string tag, input logic [3:0] v, input logic [31:0] d);
    check({tag, "_valid"}, out_valid_4, v);
    check({tag, "_data"}, out_data_4, d);
    check({tag, "_sel_err"}, sel_err_4, 1'b0);
  endtask

  initial begin
    logic [3:0] exp_v;
    logic       exp_rdy;
    int         sent;
    int         cyc;
    logic [7:0] exp_drop;

    rst_n_4 = 1'b0; in_valid_4 = 1'b0; in_sel_4 = '0; in_data_4 = '0; out_ready_4 = '0;
    rst_n_5 = 1'b0; in_valid_5 = 1'b0; in_sel_5 = '0; in_data_5 = '0; out_ready_5 = '0;
    step();
    step();

    // Reset state
    check("rst_valid", out_valid_4, 4'h0);
    check("rst_data", out_data_4, 32'h0);
    check("rst_in_ready", in_ready_4, 1'b0);
    check("rst_drop_cnt", drop_cnt_4, 8'h0);
    check("rst_sel_err", sel_err_4, 1'b0);
    check("rst5_in_ready", in_ready_5, 1'b0);
    rst_n_4 = 1'b1;
    rst_n_5 = 1'b1;
    step();

    // Steering with all consumers ready
    out_ready_4 = 4'hF;
    drive_4(1'b1, 2'd0, 8'hA5);
    check("steer_in_ready0", in_ready_4, 1'b1);
    step(); expect_out_4("steer0", 4'b0001, 32'h0000_00A5);
    drive_4(1'b1, 2'd1, 8'h3C);
    step(); expect_out_4("steer1", 4'b0010, 32'h0000_3C00);
    drive_4(1'b1, 2'd2, 8'hFF);
    step(); expect_out_4("steer2", 4'b0100, 32'h00FF_0000);
    drive_4(1'b1, 2'd3, 8'h01);
    step(); expect_out_4("steer3", 4'b1000, 32'h0100_0000);
    drive_4(1'b0, 2'd0, 8'h00);
    step(); expect_out_4("steer_idle", 4'b0000, 32'h0);

    // Back-pressure on channel 2
    out_ready_4 = 4'b1011;
    drive_4(1'b1, 2'd2, 8'h11);
    step(); expect_out_4("bp_hold", 4'b0100, 32'h0011_0000);
    drive_4(1'b1, 2'd2, 8'h22);
    check("bp_in_ready_low", in_ready_4, 1'b0);
    step(); expect_out_4("bp_stable", 4'b0100, 32'h0011_0000);
    check("bp_in_ready_still_low", in_ready_4, 1'b0);
    out_ready_4 = 4'hF;
    #1;
    check("bp_in_ready_release", in_ready_4, 1'b1);
    step(); expect_out_4("bp_second", 4'b0100, 32'h0022_0000);
    drive_4(1'b0, 2'd0, 8'h00);
    step(); expect_out_4("bp_empty", 4'b0000, 32'h0);

    // Simultaneous drain and load on channel 1 while channel 0 holds
    out_ready_4 = 4'b1100;
    drive_4(1'b1, 2'd0, 8'h77);
    step();
    drive_4(1'b1, 2'd1, 8'h55);
    step(); expect_out_4("dl_fill", 4'b0011, 32'h0000_5577);
    out_ready_4 = 4'b1110;
    drive_4(1'b1, 2'd1, 8'h66);
    check("dl_in_ready", in_ready_4, 1'b1);
    step(); expect_out_4("dl_reload", 4'b0011, 32'h0000_6677);
    drive_4(1'b0, 2'd0, 8'h00);
    step(); expect_out_4("dl_drain", 4'b0001, 32'h0000_0077);

    // Asynchronous reset with two channels holding data
    out_ready_4 = 4'b0000;
    drive_4(1'b1, 2'd2, 8'h99);
    step(); expect_out_4("ar_fill", 4'b0101, 32'h0099_0077);
    drive_4(1'b0, 2'd0, 8'h00);
    #2;
    rst_n_4 = 1'b0;
    #1;
    check("ar_valid", out_valid_4, 4'h0);
    check("ar_data", out_data_4, 32'h0);
    check("ar_drop_cnt", drop_cnt_4, 8'h0);
    check("ar_in_ready", in_ready_4, 1'b0);
    step();
    rst_n_4 = 1'b1;
    out_ready_4 = 4'hF;
    step(); expect_out_4("ar_after", 4'b0000, 32'h0);

    // Random traffic against per-channel expected queues
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid_4  = ($urandom_range(0, 3) != 0);
      in_sel_4    = 2'($urandom_range(0, 3));
      in_data_4   = 8'($urandom_range(0, 255));
      out_ready_4 = 4'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 4; k++) exp_v[k] = (exp_q[k].size() != 0);
      check("rand_valid", out_valid_4, exp_v);
      exp_rdy = (exp_q[in_sel_4].size() == 0) || out_ready_4[in_sel_4];
      check("rand_in_ready", in_ready_4, exp_rdy);
      check("rand_sel_err", sel_err_4, 1'b0);
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() != 0) begin
          check("rand_data", out_data_4[k*8 +: 8], exp_q[k][0]);
          if (out_ready_4[k]) void'(exp_q[k].pop_front());
        end else begin
          check("rand_idle", out_data_4[k*8 +: 8], 8'h00);
        end
      end
      if (in_valid_4 && in_ready_4) begin
        exp_q[in_sel_4].push_back(in_data_4);
        sent++;
      end
      step();
      cyc++;
    end
    check("rand_beats_sent", sent, 10000);
    in_valid_4 = 1'b0;
    out_ready_4 = 4'hF;
    step();
    check("rand_final_empty", out_valid_4, 4'h0);
    check("rand_drop_cnt", drop_cnt_4, 8'h0);

    // Out-of-range selects on the 5-channel instance
    out_ready_5 = 5'h1F;
    for (int i = 0; i < 300; i++) begin
      in_valid_5 = 1'b1;
      in_sel_5   = (i % 3 == 0) ? 3'd5 : 3'd7;
      in_data_5  = 8'(i);
      #1;
      check("bad_in_ready", in_ready_5, 1'b1);
      step();
      exp_drop = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
      check("bad_sel_err", sel_err_5, 1'b1);
      check("bad_valid", out_valid_5, 5'h0);
      check("bad_drop_cnt", drop_cnt_5, exp_drop);
    end
    in_valid_5 = 1'b0;
    in_sel_5   = 3'd7;
    step();
    check("bad_err_clear", sel_err_5, 1'b0);
    check("bad_drop_sat", drop_cnt_5, 8'hFF);
    step();
    check("bad_idle_no_err", sel_err_5, 1'b0);

    // Highest valid channel on the 5-channel instance still steers
    in_valid_5 = 1'b1;
    in_sel_5   = 3'd4;
    in_data_5  = 8'hC3;
    step();
    in_valid_5 = 1'b0;
    check("ch4_valid", out_valid_5, 5'b10000);
    check("ch4_data", out_data_5, 40'hC3_0000_0000);
    check("ch4_sel_err", sel_err_5, 1'b0);
    check("ch4_drop_cnt", drop_cnt_5, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
